// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART TX frame scheduler and its arbiter.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_HDR  = 3'd1,
    WAIT_HDR  = 3'd2,
    SEND_DATA = 3'd3,
    WAIT_DATA = 3'd4
  } sched_state_t;

  localparam logic [7:0]  HEADER_BASE_DEFAULT = 8'hAA;
  localparam int unsigned CLK_FREQ_HZ         = 25_000_000;
  localparam int unsigned BAUD_RATE           = 115200;

  // Next requester index after idx, wrapping at n.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return 2'd0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr, wrapping.
module rr_arbiter
  import uart_frame_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic               gnt_valid,
  output logic [1:0]         gnt_idx
);

  // Outer loop walks the search order, inner loop maps it onto a constant index.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!gnt_valid && req[j] &&
            ((32'(rr_ptr) + k == j) || (32'(rr_ptr) + k == j + NUM_REQ))) begin
          gnt_valid = 1'b1;
          gnt_idx   = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_scheduler.sv
// Round-robin scheduler sharing one UART transmitter; each grant is sent as a
// header byte followed by the payload byte, with a per-byte completion watchdog.
module uart_tx_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter logic [7:0]  HEADER_BASE     = HEADER_BASE_DEFAULT,
  parameter int unsigned TX_TIMEOUT_CLKS = 4096
) (
  input  logic                 clk_50mhz,
  input  logic                 reset_n_internal,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic                 frame_done,
  output logic                 timeout_err
);

  localparam int unsigned     WD_W    = $clog2(TX_TIMEOUT_CLKS) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_TIMEOUT_CLKS - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  sched_state_t        state;
  logic [1:0]          rr_ptr;
  logic                prev_tx_done;
  logic [7:0]          payload;
  logic [WD_W-1:0]     watchdog;

  logic                done_rise_c;
  logic                gnt_valid_c;
  logic [1:0]          gnt_idx_c;
  logic [1:0]          rr_next_c;
  logic [7:0]          gnt_byte_c;
  logic [NUM_REQ-1:0]  gnt_onehot_c;

  assign done_rise_c = tx_done & ~prev_tx_done;
  assign rr_next_c   = wrap_inc(grant_id, NUM_REQ);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid_c),
    .gnt_idx   (gnt_idx_c)
  );

  // Payload slice and ack one-hot for the current arbitration winner.
  always_comb begin
    gnt_byte_c   = '0;
    gnt_onehot_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_c == 2'(i)) begin
        gnt_byte_c      = req_byte[8*i +: 8];
        gnt_onehot_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset_n_internal) begin
    if (!reset_n_internal) begin
      state        <= IDLE;
      req_ack      <= '0;
      tx_dv        <= 1'b0;
      tx_byte      <= 8'h00;
      busy         <= 1'b0;
      grant_id     <= 2'd0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
      rr_ptr       <= 2'd0;
      prev_tx_done <= 1'b0;
      payload      <= 8'h00;
      watchdog     <= '0;
    end else begin
      prev_tx_done <= tx_done;
      req_ack      <= '0;
      tx_dv        <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (gnt_valid_c) begin
            grant_id <= gnt_idx_c;
            payload  <= gnt_byte_c;
            req_ack  <= gnt_onehot_c;
            busy     <= 1'b1;
            state    <= SEND_HDR;
          end
        end

        SEND_HDR: begin
          if (!tx_active) begin
            tx_dv    <= 1'b1;
            tx_byte  <= HEADER_BASE + {6'd0, grant_id};
            watchdog <= '0;
            state    <= WAIT_HDR;
          end
        end

        // Completion beats a same-cycle timeout because it is tested first.
        WAIT_HDR: begin
          if (done_rise_c) begin
            state <= SEND_DATA;
          end else if (watchdog == WD_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            rr_ptr      <= rr_next_c;
            state       <= IDLE;
          end else if (watchdog != WD_MAX) begin
            watchdog <= watchdog + WD_W'(1);
          end
        end

        SEND_DATA: begin
          if (!tx_active) begin
            tx_dv    <= 1'b1;
            tx_byte  <= payload;
            watchdog <= '0;
            state    <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          if (done_rise_c) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            rr_ptr     <= rr_next_c;
            state      <= IDLE;
          end else if (watchdog == WD_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            rr_ptr      <= rr_next_c;
            state       <= IDLE;
          end else if (watchdog != WD_MAX) begin
            watchdog <= watchdog + WD_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame_scheduler.md
Name: uart_tx_frame_scheduler

Overview:
Shares the single UART transmitter between NUM_REQ byte producers (requester 0 is the filtered echo path, requester 1 is the status/telemetry path). Each granted request goes out as a two-byte frame: a header byte (HEADER_BASE + requester index), then the payload byte. Requesters are served round-robin. The block sits between the producers and the uart_top TX handshake (tx_dv/tx_byte/tx_active/tx_done). A watchdog aborts frames whose transmitter never completes.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
HEADER_BASE, 8'hAA, header sent for requester 0; requester i sends HEADER_BASE+i (modulo 256)
TX_TIMEOUT_CLKS, 4096, max clocks from a tx_dv pulse to the tx_done rising edge (one 115200-baud byte at 25 MHz is about 2170 clocks)

Ports:
clk_50mhz  in  1  system clock (25 MHz actual)
reset_n_internal  in  1  async active-low reset
req_valid  in  NUM_REQ  requester i has a byte pending; held until req_ack[i]
req_byte  in  8*NUM_REQ  payload; slice i = [8*i+7:8*i], valid while req_valid[i]
req_ack  out  NUM_REQ  one-cycle pulse: payload latched, requester may drop or change valid
tx_dv  out  1  one-cycle launch strobe to uart_top
tx_byte  out  8  byte to transmit; stable from the tx_dv cycle until the next launch
tx_active  in  1  transmitter busy
tx_done  in  1  transmitter completion (level or pulse; only the rising edge is used)
busy  out  1  high in every state except IDLE
grant_id  out  2  index of the requester currently or last served
frame_done  out  1  one-cycle pulse when the payload byte completes
timeout_err  out  1  one-cycle pulse on a watchdog abort

Behaviour:
- Reset: state=IDLE; req_ack=0, tx_dv=0, tx_byte=8'h00, busy=0, grant_id=0, frame_done=0, timeout_err=0; rr_ptr=0; prev_tx_done=0; latched payload=0; watchdog=0.
- tx_done edge: prev_tx_done registers tx_done every cycle. done_rise = tx_done & ~prev_tx_done.
- Arbitration: search order starts at rr_ptr and goes up, wrapping modulo NUM_REQ. The first asserted req_valid wins.
- IDLE, any req_valid set: grant winner w, latch req_byte[w], req_ack[w]=1 for one cycle, grant_id<=w, go to SEND_HDR. Only one ack per frame.
- SEND_HDR: wait while tx_active. When it is low, tx_dv=1 and tx_byte=HEADER_BASE+w, clear the watchdog, go to WAIT_HDR.
  - Latency: valid seen in IDLE at cycle c gives ack at c+1 and tx_dv at c+2 (registered outputs).
- WAIT_HDR:
  - done_rise: go to SEND_DATA.
  - watchdog == TX_TIMEOUT_CLKS-1 without done_rise: timeout_err pulse, go to IDLE, rr_ptr<=w+1.
- SEND_DATA: same as SEND_HDR but tx_byte=latched payload. Go to WAIT_DATA.
- WAIT_DATA:
  - done_rise: frame_done pulse, rr_ptr<=(w+1) mod NUM_REQ, go to IDLE.
  - Timeout: handled as in WAIT_HDR.
- Watchdog: counts only in WAIT_* states and saturates; its width is $clog2(TX_TIMEOUT_CLKS)+1.
- A done_rise seen outside WAIT_* is ignored. A done_rise and a timeout in the same cycle: done_rise wins.
- req_valid dropped before ack: not served, no ack. A requester that drops valid after ack does not affect the frame in flight.
- Back-to-back: IDLE lasts at least one cycle between frames. The next grant goes to the next requester even if the same one is still valid.
- Unknown or unused state encoding: go to IDLE.
- Reset mid-frame: returns to IDLE immediately, tx_dv=0. The byte already handed to the UART may still finish; its tx_done edge is ignored.
- tx_dv is never asserted two cycles in a row and never while tx_active=1.

Decomposition:
- Package uart_frame_pkg:
  - sched_state_t enum logic[2:0] {IDLE, SEND_HDR, WAIT_HDR, SEND_DATA, WAIT_DATA}
  - HEADER_BASE_DEFAULT=8'hAA
  - CLK_FREQ_HZ=25_000_000, BAUD_RATE=115200
- Sub-module rr_arbiter (purely combinational): inputs req and rr_ptr; outputs gnt_valid and gnt_idx. Reused by the future RX demux.

Test Plan:
- Single request: req_valid[0]=1, byte 8'h37, UART model completes in 2170 clocks -> ack[0] one pulse, TX sequence 8'hAA then 8'h37, one frame_done, grant_id=0.
- Contention: both valid (r0=8'h10, r1=8'h20), held valid after each ack with a new byte -> frames go r0, r1, r0, r1; headers alternate 8'hAA/8'hAB; no back-to-back grant to the same requester.
- Watchdog: UART model never raises tx_done after the header -> timeout_err after exactly 4096 clocks in WAIT_HDR, state IDLE, no payload launch, next grant goes to r1.
- tx_active held high for 500 clocks before the launch -> tx_dv waits until it drops, then pulses once. Assertion over the whole run: tx_dv never high while tx_active is high.
- Edge/level tx_done: tx_done held high for 3000 clocks -> counted as one completion only, exactly one payload launch per frame.
- Reset in WAIT_DATA (reset_n_internal low for 3 clocks) -> all outputs at reset values, tx_done edge after release ignored, next request framed normally.
